peak_period_monitor: RTL
========================

// Module: peak_period_monitor
// PURPOSE
//  Downstream checker for the load/store ramp generator's peak flag (sig).
//  Detects rising edges of sig, measures cycles between consecutive peaks,
//  counts peaks, and raises a sticky fault when a period falls outside
//  EXP_PERIOD +/- TOL or no peak arrives within TIMEOUT cycles.
// PARAMETERS
//  EXP_PERIOD  45002  expected rise-to-rise period in cycles (2*N+2 for N=22500)
//  TOL         2      allowed +/- deviation from EXP_PERIOD, inclusive
//  TIMEOUT     50000  cycles without a rise before a timeout fault
//  PBITS       17     width of period counter / last_period
//  CBITS       16     width of peak counter
//  Legal only if EXP_PERIOD+TOL < TIMEOUT < 2**PBITS-1 and TOL < EXP_PERIOD.
// PORTS
//  clk          in   1      clock, all logic on posedge
//  rst          in   1      synchronous reset, active-low
//  sig_in       in   1      peak flag from ramp generator (may stay high >1 cycle)
//  clr_fault    in   1      level; leaves FAULT when asserted in FAULT
//  peak_cnt     out  CBITS  number of counted rising edges, saturating
//  last_period  out  PBITS  most recent measured period
//  period_vld   out  1      one-cycle pulse when last_period updates
//  fault        out  1      high while in FAULT
//  fault_code   out  2      00 none, 01 early, 10 late, 11 timeout
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=WAIT_FIRST, sig_q=0, per_cnt=0, all
//   outputs 0. Reset mid-operation discards everything, same values.
//  rise = sig_in & ~sig_q; sig_q <= sig_in every cycle (1 cycle latency).
//   sig_in high on first post-reset cycle counts as a rise.
//  per_cnt: on rise <= 1; else <= per_cnt+1, saturating at all-ones.
//   Thus at a rise, per_cnt = cycles since previous rise.
//  States:
//   WAIT_FIRST: rise -> TRACK, peak_cnt++; no period check, no period_vld.
//     per_cnt == TIMEOUT (no rise) -> FAULT, code 11.
//   TRACK: on rise: last_period<=per_cnt, period_vld=1 next cycle, peak_cnt++;
//     per_cnt < EXP_PERIOD-TOL -> FAULT code 01;
//     per_cnt > EXP_PERIOD+TOL -> FAULT code 10; else stay TRACK.
//     per_cnt == TIMEOUT, no rise -> FAULT code 11.
//   FAULT: fault=1, code held; rises ignored (no count, no period update),
//     per_cnt keeps running. clr_fault=1 -> WAIT_FIRST, per_cnt<=0,
//     fault<=0, code<=00; a rise in that same cycle is ignored.
//  clr_fault outside FAULT has no effect.
//  Rise and per_cnt==TIMEOUT in same cycle: rise wins, period is checked.
//  Boundaries inclusive: period == EXP_PERIOD-TOL or EXP_PERIOD+TOL passes.
//  peak_cnt saturates at 2**CBITS-1, never wraps.
//  Outputs registered; fault/fault_code/period_vld/last_period all update
//   on the posedge after the rise is sampled.
// TESTING (bench params EXP_PERIOD=10, TOL=1, TIMEOUT=20, PBITS=6, CBITS=4)
//  1. Rises every 10 cycles x5 -> peak_cnt=5, 4 period_vld pulses,
//     last_period=10, fault=0.
//  2. Periods 9 then 11 -> both pass (inclusive edges); period 8 -> fault=1,
//     code=01, last_period=8; further rises do not change peak_cnt.
//  3. Period 12 -> fault=1, code=10; clr_fault 1 cycle -> fault=0, code=00,
//     WAIT_FIRST; next rise counts but gives no period_vld.
//  4. No rise after reset for 20 cycles -> code=11; rise exactly at per_cnt==20
//     in TRACK -> evaluated as late (code 10), not timeout.
//  5. sig_in held high 2 cycles per peak (ramp generator pattern) -> one count
//     per peak; 20 rises with CBITS=4 -> peak_cnt saturates at 15.
//  6. rst low mid-TRACK with fault pending -> all outputs 0 next cycle, state
//     WAIT_FIRST; clr_fault together with rise in FAULT -> rise not counted.

Source files
------------

// File: rtl/peak_period_monitor_if.sv
// Bundles the peak flag input, fault clear and all monitor results.
interface peak_period_monitor_if #(
    parameter int PBITS = 17,
    parameter int CBITS = 16
) ();
    logic             sig_in;
    logic             clr_fault;
    logic [CBITS-1:0] peak_cnt;
    logic [PBITS-1:0] last_period;
    logic             period_vld;
    logic             fault;
    logic [1:0]       fault_code;

    modport master (
        output sig_in, clr_fault,
        input  peak_cnt, last_period, period_vld, fault, fault_code
    );

    modport slave (
        input  sig_in, clr_fault,
        output peak_cnt, last_period, period_vld, fault, fault_code
    );
endinterface

// File: rtl/peak_period_monitor.sv
// Checks the ramp generator's peak flag: counts rising edges, measures the
// rise-to-rise period and latches a sticky fault on an out-of-window period
// or when no peak arrives within TIMEOUT cycles.
module peak_period_monitor #(
    parameter int EXP_PERIOD = 45002,
    parameter int TOL        = 2,
    parameter int TIMEOUT    = 50000,
    parameter int PBITS      = 17,
    parameter int CBITS      = 16
) (
    input logic               clk,
    input logic               rst,
    peak_period_monitor_if.slave bus
);
    localparam logic [PBITS-1:0] PER_LO  = PBITS'(EXP_PERIOD - TOL);
    localparam logic [PBITS-1:0] PER_HI  = PBITS'(EXP_PERIOD + TOL);
    localparam logic [PBITS-1:0] PER_TO  = PBITS'(TIMEOUT);
    localparam logic [PBITS-1:0] PER_MAX = '1;
    localparam logic [CBITS-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_WAIT_FIRST = 2'd0,
        S_TRACK      = 2'd1,
        S_FAULT      = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_sig_q;
    logic [PBITS-1:0] r_per_cnt, w_per_cnt_nxt;
    logic [CBITS-1:0] r_peak_cnt, w_peak_cnt_nxt;
    logic [PBITS-1:0] r_last_period, w_last_period_nxt;
    logic             r_period_vld, w_period_vld_nxt;
    logic [1:0]       r_code, w_code_nxt;
    logic             w_rise;
    logic             w_timeout;
    logic [CBITS-1:0] w_peak_inc;

    assign w_rise     = bus.sig_in & ~r_sig_q;
    assign w_timeout  = (r_per_cnt == PER_TO);
    assign w_peak_inc = (r_peak_cnt == CNT_MAX) ? r_peak_cnt : r_peak_cnt + 1'b1;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_WAIT_FIRST;
        else      r_state <= w_state_nxt;
    end

    // Next-state logic and next values of counters and registered outputs
    always_comb begin
        w_state_nxt       = r_state;
        w_per_cnt_nxt     = w_rise ? PBITS'(1)
                          : ((r_per_cnt == PER_MAX) ? r_per_cnt : r_per_cnt + 1'b1);
        w_peak_cnt_nxt    = r_peak_cnt;
        w_last_period_nxt = r_last_period;
        w_period_vld_nxt  = 1'b0;
        w_code_nxt        = r_code;
        case (r_state)
            S_WAIT_FIRST: begin
                if (w_rise) begin
                    w_state_nxt    = S_TRACK;
                    w_peak_cnt_nxt = w_peak_inc;
                end else if (w_timeout) begin
                    w_state_nxt = S_FAULT;
                    w_code_nxt  = 2'b11;
                end
            end
            S_TRACK: begin
                // A rise coinciding with the timeout count is judged as a period
                if (w_rise) begin
                    w_last_period_nxt = r_per_cnt;
                    w_period_vld_nxt  = 1'b1;
                    w_peak_cnt_nxt    = w_peak_inc;
                    if (r_per_cnt < PER_LO) begin
                        w_state_nxt = S_FAULT;
                        w_code_nxt  = 2'b01;
                    end else if (r_per_cnt > PER_HI) begin
                        w_state_nxt = S_FAULT;
                        w_code_nxt  = 2'b10;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = S_FAULT;
                    w_code_nxt  = 2'b11;
                end
            end
            S_FAULT: begin
                // Rises are ignored here, including one coinciding with the clear
                if (bus.clr_fault) begin
                    w_state_nxt   = S_WAIT_FIRST;
                    w_per_cnt_nxt = '0;
                    w_code_nxt    = 2'b00;
                end
            end
            default: begin
                w_state_nxt = S_WAIT_FIRST;
                w_code_nxt  = 2'b00;
            end
        endcase
    end

    // Edge detector, period counter and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sig_q       <= 1'b0;
            r_per_cnt     <= '0;
            r_peak_cnt    <= '0;
            r_last_period <= '0;
            r_period_vld  <= 1'b0;
            r_code        <= 2'b00;
        end else begin
            r_sig_q       <= bus.sig_in;
            r_per_cnt     <= w_per_cnt_nxt;
            r_peak_cnt    <= w_peak_cnt_nxt;
            r_last_period <= w_last_period_nxt;
            r_period_vld  <= w_period_vld_nxt;
            r_code        <= w_code_nxt;
        end
    end

    assign bus.peak_cnt    = r_peak_cnt;
    assign bus.last_period = r_last_period;
    assign bus.period_vld  = r_period_vld;
    assign bus.fault       = (r_state == S_FAULT);
    assign bus.fault_code  = r_code;
endmodule
